// File: rtl/odb_rs232.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : odb_rs232
// Brief    : RS-232 receiver. Synchronises RXD, validates the start bit,
//            samples each bit at mid-bit and strobes out the byte and errors.
//            Optional parity bit is compiled in with RS232_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module odb_rs232 #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       RXD_i,
    output logic [7:0] bdata_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);

    if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("odb_rs232: CLKS_PER_BIT must be >= 4 and PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RS232_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t           state_q,  state_d;
    logic             sync1_q,  sync1_d;
    logic             rxs_q,    rxs_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bitn_q,   bitn_d;
    logic [7:0]       shreg_q,  shreg_d;
    logic [7:0]       bdata_q,  bdata_d;
    logic             valid_q,  valid_d;
    logic             ferr_q,   ferr_d;
    logic             busy_q,   busy_d;
`ifdef RS232_PARITY_EN
    localparam logic C_PAR_ODD = 1'(PARITY_ODD);
    logic             par_q,    par_d;
    logic             perr_q,   perr_d;
`endif

    always_comb begin
        state_d = state_q;
        sync1_d = RXD_i;
        rxs_d   = sync1_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shreg_d = shreg_q;
        bdata_d = bdata_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef RS232_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end

            // Re-check the line half a bit in so that short low glitches are dropped.
            ST_START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    bitn_d  = '0;
                    state_d = rxs_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bitn_d  = bitn_q + 1'b1;
                    if (bitn_q == 3'd7) begin
`ifdef RS232_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef RS232_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rxs_q;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        bdata_d = shreg_q;
                        valid_d = 1'b1;
`ifdef RS232_PARITY_EN
                        perr_d  = ((^shreg_q) ^ C_PAR_ODD) != par_q;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A line held low after a bad stop bit must not look like a new start.
            ST_BREAK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shreg_q <= '0;
            bdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RS232_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            rxs_q   <= rxs_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shreg_q <= shreg_d;
            bdata_q <= bdata_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
`ifdef RS232_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bdata_o     = bdata_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = busy_q;
`ifdef RS232_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/odb_rs232.md
# odb_rs232

RS-232 serial receiver for the RS-232 handling path. It sits on the line side of the design, opposite the transmitter, and consumes the serial stream that the transmitter produces on its TXD output. It also accepts an external RXD pin. The block synchronises RXD, detects and validates the start bit, samples each bit at mid-bit, and presents the received byte with a one-cycle valid strobe plus error flags.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per bit. 5208 gives 9600 Bd at 50 MHz. Must be ≥ 4.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity. Used only when parity is compiled in.

- clk_i  in  1  system clock; every register updates on its rising edge
- rst_i  in  1  reset; synchronous and active-high
- RXD_i  in  1  serial line; idles high
- bdata_o  out  8  last good byte; held until the next good frame
- rx_valid_o  out  1  one-cycle strobe; a new byte is on bdata_o
- parity_err_o  out  1  one-cycle strobe coincident with rx_valid_o; parity mismatch
- frame_err_o  out  1  one-cycle strobe; stop bit sampled low
- busy_o  out  1  high in every state except IDLE

## Operation
- **Line format:** 1 start bit (0), 8 data bits sent LSB first, optional parity bit, 1 stop bit (1).
- **Input sync:** RXD_i passes through a 2-FF synchroniser. The block uses only the synchronised value rxs.
- **Counters:** bit-time counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, floored.
- **States:**
  - IDLE: when rxs = 0, go to START and clear the counter.
  - START: at count = HALF-1, sample rxs. If rxs = 0, go to DATA with counter cleared. If rxs = 1, the start was a glitch; return to IDLE with no strobe.
  - DATA: at count = CLKS_PER_BIT-1, shift rxs into bit 7 of the shift register (shift right) and clear the counter. After the 8th sample, go to PARITY if compiled in, otherwise STOP.
  - PARITY: at count = CLKS_PER_BIT-1, sample and store the parity bit, then go to STOP.
  - STOP: at count = CLKS_PER_BIT-1, sample rxs.
    - rxs = 1: load bdata_o with the shift register and pulse rx_valid_o. Pulse parity_err_o in the same cycle on mismatch. Go to IDLE.
    - rxs = 0: pulse frame_err_o only. bdata_o is unchanged. Go to BREAK.
  - BREAK: wait for rxs = 1, then go to IDLE. A line held low never starts a new frame.
- **Parity check:** the expected bit is XOR of the 8 data bits, XOR PARITY_ODD. A parity error does not suppress delivery.
- **Reset:** rst_i overrides everything, including mid-frame. It gives state IDLE, counter 0, shift register 0, and synchroniser flops 1.

## Timing
- Reset values: bdata_o = 8'h00, rx_valid_o = 0, parity_err_o = 0, frame_err_o = 0, busy_o = 0.
- Strobes are registered and last exactly one cycle. No handshake and no back-pressure: the consumer must take bdata_o on the rx_valid_o cycle or before the next frame completes.
- Latency is counted from the first clk_i edge that samples RXD_i low to the edge where rx_valid_o (or frame_err_o) rises:
  - without parity: 2 + HALF + 9·CLKS_PER_BIT cycles
  - with parity: 2 + HALF + 10·CLKS_PER_BIT cycles
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample. A start edge arriving half a bit after the stop sample must be caught.
- Glitch rejection: a low pulse on rxs shorter than HALF cycles produces no strobe and no state change beyond START→IDLE.
- busy_o rises the cycle after rxs is first seen low. It falls the cycle after the stop sample, or the cycle after BREAK ends.

## Configuration
- RS232_PARITY_EN
  - Defined: the PARITY state exists and the frame is 11 bits. parity_err_o operates as described above.
  - Undefined: the PARITY state is removed and the frame is 10 bits. parity_err_o is tied to 0.

## Test plan
- CLKS_PER_BIT=5, no parity: send 0xA5 -> rx_valid_o pulses once, bdata_o = 0xA5, both error flags 0, latency 2+2+45 = 49 cycles.
- RS232_PARITY_EN, PARITY_ODD=0:
  - send 0x03 with parity bit 0 -> valid, bdata_o = 0x03, parity_err_o = 0.
  - send 0x03 with parity bit 1 -> valid together with parity_err_o = 1.
- RXD_i low for 1 cycle, then high -> no strobe, busy_o returns to 0 within HALF+3 cycles.
- Send 0x5A with stop bit 0, then hold the line low 30 cycles, then high:
  - frame_err_o pulses once, bdata_o keeps its previous value.
  - no further strobe while low.
  - a following 0x11 frame is received correctly.
- Assert rst_i mid-DATA of 0xFF -> all outputs 0 next cycle, no strobe for the aborted frame, next frame 0x42 received correctly.
- Two frames back-to-back, 0x00 then 0xFF, no idle gap -> two rx_valid_o pulses, 50 cycles apart, with the correct data each time.
